// File: rtl/router_east_wght_tx_pkg.sv
// Shared router definitions.
// Holds the transmit FSM encoding, the default link/GLB widths shared with
// the west-side receivers, and the GLB read latency.
package router_east_wght_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    localparam int ROUTER_DATA_BITWIDTH     = 16;
    localparam int ROUTER_ADDR_BITWIDTH_GLB = 10;

    // Cycles from a GLB read request to its data on glb_data_i.
    localparam int GLB_READ_LATENCY = 1;

endpackage

// File: rtl/router_east_wght_tx_glb_read_pipe.sv
// GLB read pipeline for the east weight transmitter.
// Delays each read request by the GLB latency so it lines up with its
// returned data, then registers that data onto the link.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req          : read request issued this cycle
//   glb_data_i   : GLB read data (valid LATENCY cycles after req)
//   data_o       : registered link data, 0 whenever enable_o is 0
//   enable_o     : registered link valid
//   inflight     : a request is still on its way to the link register
module router_east_wght_tx_glb_read_pipe
    import router_east_wght_tx_pkg::*;
#(
    parameter int DATA_BITWIDTH = ROUTER_DATA_BITWIDTH,
    parameter int LATENCY       = GLB_READ_LATENCY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [DATA_BITWIDTH-1:0] glb_data_i,
    output logic [DATA_BITWIDTH-1:0] data_o,
    output logic                     enable_o,
    output logic                     inflight
);

    logic [LATENCY-1:0] req_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sr   <= '0;
            data_o   <= '0;
            enable_o <= 1'b0;
        end else begin
            req_sr[0] <= req;
            for (int i = 1; i < LATENCY; i++) begin
                req_sr[i] <= req_sr[i-1];
            end
            enable_o <= req_sr[LATENCY-1];
            // Gate the data so nothing but real weights (or zero) reaches the link.
            data_o   <= req_sr[LATENCY-1] ? glb_data_i : '0;
        end
    end

    assign inflight = |req_sr;

endmodule

// File: rtl/router_east_wght_tx.sv
// East-side weight link transmitter.
// On start, reads num_words contiguous weight words from the GLB beginning at
// base_addr and sends them as one unbroken enable burst, then holds enable low
// for GAP_CYCLES so the receiver's rising-edge detector re-arms.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   start, base_addr, num_words : burst request (accepted only when idle)
//   glb_addr_read, glb_req_read : GLB read port
//   glb_data_i                  : GLB read data
//   east_data_o, east_enable_o  : link toward neighbour's west port
//   busy                        : FSM not idle
//   done                        : one-cycle pulse in the final gap cycle
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_READ  | issuing one GLB read per cycle
// ST_DRAIN | waiting for the last word to reach the link
// ST_GAP   | enable held low; done in the last cycle
module router_east_wght_tx
    import router_east_wght_tx_pkg::*;
#(
    parameter int DATA_BITWIDTH     = ROUTER_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = ROUTER_ADDR_BITWIDTH_GLB,
    parameter int LEN_BITWIDTH      = 10,
    parameter int GAP_CYCLES        = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_BITWIDTH_GLB-1:0] base_addr,
    input  logic [LEN_BITWIDTH-1:0]      num_words,
    output logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_read,
    output logic                         glb_req_read,
    input  logic [DATA_BITWIDTH-1:0]     glb_data_i,
    output logic [DATA_BITWIDTH-1:0]     east_data_o,
    output logic                         east_enable_o,
    output logic                         busy,
    output logic                         done
);

    localparam int               GAP_BITS = 4;
    localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'(GAP_CYCLES - 1);

    tx_state_e                    state_q, state_d;
    logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;
    logic [LEN_BITWIDTH-1:0]      remain_q, remain_d;
    logic [GAP_BITS-1:0]          gap_q, gap_d;
    logic                         req;
    logic                         done_c;
    logic                         pipe_inflight;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        gap_d    = gap_q;
        req      = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        addr_d   = base_addr;
                        remain_d = num_words;
                        state_d  = ST_READ;
                    end else begin
                        // Empty burst still observes the gap so done keeps its timing.
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_READ: begin
                req      = 1'b1;
                addr_d   = addr_q + 1'b1;  // wraps modulo the GLB depth
                remain_d = remain_q - 1'b1;
                if (remain_q == LEN_BITWIDTH'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Once nothing is in flight, the last word is on the link this cycle.
                if (!pipe_inflight) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    router_east_wght_tx_glb_read_pipe #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .LATENCY       (GLB_READ_LATENCY)
    ) u_read_pipe (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .glb_data_i (glb_data_i),
        .data_o     (east_data_o),
        .enable_o   (east_enable_o),
        .inflight   (pipe_inflight)
    );

    assign glb_req_read  = req;
    assign glb_addr_read = req ? addr_q : '0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_c;

endmodule

// File: doc/router_east_wght_tx.md
Name: router_east_wght_tx

Overview:
- Transmit end of the west-bound weight link between adjacent routers.
- On a start command, reads a contiguous block of weight words from the local weight GLB.
- Streams the words to the neighbouring router's west port as one unbroken data/enable burst.
- Enforces a low-enable gap after each burst so the receiver's enable rising-edge detector re-arms for the next burst.

Parameters:
- DATA_BITWIDTH, 16, width of one weight word and of the link data bus.
- ADDR_BITWIDTH_GLB, 10, weight GLB address width.
- LEN_BITWIDTH, 10, width of the burst-length field.
- GAP_CYCLES, 2, cycles the link enable is held low after a burst (legal range 1..15).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, single-cycle burst request; sampled only in IDLE.
- base_addr, input, ADDR_BITWIDTH_GLB, first GLB address of the burst; latched on accepted start.
- num_words, input, LEN_BITWIDTH, burst length; latched on accepted start.
- glb_addr_read, output, ADDR_BITWIDTH_GLB, GLB read address.
- glb_req_read, output, 1, GLB read request; data returns on glb_data_i exactly 1 cycle later.
- glb_data_i, input, DATA_BITWIDTH, GLB read data.
- east_data_o, output, DATA_BITWIDTH, link data toward the neighbour's west port.
- east_enable_o, output, 1, link valid; high for the whole burst.
- busy, output, 1, high whenever the FSM is not in IDLE.
- done, output, 1, one-cycle pulse at the end of GAP.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- FSM states: IDLE, READ, DRAIN, GAP.
- IDLE:
  - start=1 with num_words>0: latch base_addr and num_words, go to READ.
  - start=1 with num_words=0: no GLB access; go directly to GAP, so done still pulses after the gap.
- READ:
  - glb_req_read=1 and glb_addr_read=base+i for i=0..num_words-1, one request per cycle, no bubbles.
  - Address increment wraps modulo 2^ADDR_BITWIDTH_GLB.
  - After the last request, go to DRAIN.
- Data pipeline:
  - A request issued in cycle k yields glb_data_i valid in k+1.
  - That data is registered to east_data_o with east_enable_o=1 in cycle k+2.
  - Consequence: start accepted in cycle T gives the first request at T+1 and the first link word at T+3.
  - east_enable_o is high for exactly num_words consecutive cycles.
- DRAIN: waits until the last word has appeared on the link, then goes to GAP.
- east_data_o is 0 in every cycle where east_enable_o=0. No X values reach the link.
- GAP:
  - east_enable_o held 0 for GAP_CYCLES cycles.
  - done=1 in the final GAP cycle, then IDLE.
  - The earliest next accepted start is the cycle after done.
- start while busy=1 is ignored. It is not queued and has no effect on the latched values.
- Maximum burst: num_words=2^LEN_BITWIDTH-1. The address may wrap mid-burst, e.g. base=1022, num_words=4 reads 1022, 1023, 0, 1.
- Reset asserted mid-burst: the next cycle shows all outputs 0 and the FSM in IDLE. Any in-flight GLB data is discarded, and no done pulse is issued for the aborted burst.
- Protocol guarantee to the receiver: each burst begins with a 0→1 enable edge preceded by at least GAP_CYCLES low cycles.

Decomposition:
- Shared router package holds:
  - the FSM state encoding (2-bit IDLE/READ/DRAIN/GAP);
  - the default DATA/ADDR widths shared with the west receiver routers;
  - the GLB read-latency constant (1).
- One natural sub-module: glb_read_pipe, containing the request/valid delay line and the output data register. The FSM and counters stay in the top module.

Test Plan:
- Basic burst:
  - Stimulus: reset, then start at T with base=0x010, num_words=3; GLB returns addr+0x100.
  - Required: requests at 0x010/0x011/0x012 in T+1..T+3; east_enable_o high T+3..T+5 with data 0x110/0x111/0x112.
  - Required: enable low for 2 cycles, done pulses at T+7.
- Zero length:
  - Stimulus: start with num_words=0.
  - Required: glb_req_read never asserts, east_enable_o stays 0, done pulses GAP_CYCLES cycles later, busy high in between.
- Address wrap:
  - Stimulus: base=1022, num_words=4.
  - Required: addresses 1022, 1023, 0, 1; four contiguous enable cycles.
- Start while busy:
  - Stimulus: start pulses during READ and GAP of a 5-word burst.
  - Required: exactly one 5-word burst and one done; the second burst starts only after an IDLE start.
- Reset mid-burst:
  - Stimulus: assert reset on the 2nd enable cycle of an 8-word burst.
  - Required: next cycle all outputs 0; no done; a fresh start works normally.
- Back-to-back with receiver:
  - Stimulus: connect east_* to the west weight receiver; send two 4-word bursts separated only by the mandatory gap.
  - Required: the receiver sees two distinct enable rising edges, i.e. two load triggers.
